// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 phase scheduler and its S-memory port mux.
package arc4_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int KEY_W  = 24;
  localparam int PH_W   = 2;
  localparam int CYC_W  = 32;

  localparam logic [PH_W-1:0] PH_IDLE = 2'd0;
  localparam logic [PH_W-1:0] PH_INIT = 2'd1;
  localparam logic [PH_W-1:0] PH_KSA  = 2'd2;
  localparam logic [PH_W-1:0] PH_PRGA = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_GO,
    S_INIT_RUN,
    S_KSA_GO,
    S_KSA_RUN,
    S_PRGA_GO,
    S_PRGA_RUN
  } state_t;

endpackage

// File: rtl/arc4_smem_mux.sv
// 3:1 S-memory port mux, selected by phase; combinational, zero latency, no backpressure.
// Idle drives an inert port so no engine write can leak through.
module arc4_smem_mux
  import arc4_pkg::*;
(
  input  logic [PH_W-1:0]   phase,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      PH_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PH_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// Sequences ARC4 init -> KSA -> PRGA engines; engine start one cycle after accept, rdy one cycle after PRGA done.
// en ignored while busy (no queuing); engine starts wait on engine rdy. ARC4_SCHED_CYCLE_COUNT_EN adds a cycles output.
module arc4_sched
  import arc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
`ifdef ARC4_SCHED_CYCLE_COUNT_EN
  output logic [CYC_W-1:0]  cycles,
`endif
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  key,
  output logic [KEY_W-1:0]  key_q,
  output logic [PH_W-1:0]   phase,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  state_t state;
  logic   run_armed;

  // Engine starts follow engine rdy in the same cycle so a stalled GO issues its pulse the cycle rdy rises.
  assign init_en = (state == S_INIT_GO) && init_rdy;
  assign ksa_en  = (state == S_KSA_GO)  && ksa_rdy;
  assign prga_en = (state == S_PRGA_GO) && prga_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rdy       <= 1'b1;
      key_q     <= '0;
      phase     <= PH_IDLE;
      run_armed <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_INIT_GO;
            key_q <= key;
            rdy   <= 1'b0;
            phase <= PH_INIT;
          end
        end
        S_INIT_GO: begin
          run_armed <= 1'b0;
          if (init_rdy) state <= S_INIT_RUN;
        end
        // The engine still shows rdy on its first busy cycle, so the first RUN cycle is ignored.
        S_INIT_RUN: begin
          run_armed <= 1'b1;
          if (run_armed && init_rdy) begin
            state <= S_KSA_GO;
            phase <= PH_KSA;
          end
        end
        S_KSA_GO: begin
          run_armed <= 1'b0;
          if (ksa_rdy) state <= S_KSA_RUN;
        end
        S_KSA_RUN: begin
          run_armed <= 1'b1;
          if (run_armed && ksa_rdy) begin
            state <= S_PRGA_GO;
            phase <= PH_PRGA;
          end
        end
        S_PRGA_GO: begin
          run_armed <= 1'b0;
          if (prga_rdy) state <= S_PRGA_RUN;
        end
        S_PRGA_RUN: begin
          run_armed <= 1'b1;
          if (run_armed && prga_rdy) begin
            state <= S_IDLE;
            phase <= PH_IDLE;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          phase <= PH_IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

`ifdef ARC4_SCHED_CYCLE_COUNT_EN
  // Counts busy cycles of the last run; frozen while idle so software can read it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
    end else if (state == S_IDLE) begin
      if (en) cycles <= '0;
    end else if (cycles != {CYC_W{1'b1}}) begin
      cycles <= cycles + 1'b1;
    end
  end
`endif

  arc4_smem_mux u_smem_mux (
    .phase       (phase),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );

endmodule

// File: doc/arc4_sched.md
ARC4_SCHED -- requirements
Module: arc4_sched

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  start request; sampled only while rdy=1.
REQ-004 rdy  output  1  1 = idle and able to accept en.
REQ-005 key  input  24  ARC4 key; latched on accepted en.
REQ-006 key_q  output  24  latched key, driven to KSA and PRGA engines.
REQ-007 phase  output  2  0 idle, 1 init, 2 ksa, 3 prga (LEDR debug).
REQ-008 init_en/ksa_en/prga_en  output  1 each  one-cycle engine start pulses.
REQ-009 init_rdy/ksa_rdy/prga_rdy  input  1 each  engine ready; drops the cycle after its en, rises on completion.
REQ-010 init_addr/ksa_addr/prga_addr  input  8 each  engine S-memory address.
REQ-011 init_wrdata/ksa_wrdata/prga_wrdata  input  8 each  engine S-memory write data.
REQ-012 init_wren/ksa_wren/prga_wren  input  1 each  engine S-memory write enable.
REQ-013 s_addr  output  8, s_wrdata  output  8, s_wren  output  1  shared single-port S-memory port.

Function
REQ-014 States: IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN.
REQ-015 IDLE: rdy=1; en=1 -> latch key into key_q, go INIT_GO; en=0 -> stay.
REQ-016 rdy registered: 1 only in IDLE; en while rdy=0 ignored, no queuing.
REQ-017 X_GO: assert X_en for one cycle only when X_rdy=1, then go X_RUN; X_rdy=0 -> hold X_GO, X_en=0.
REQ-018 X_RUN: first cycle ignores X_rdy; afterwards X_rdy=1 -> next phase GO (INIT->KSA->PRGA), PRGA_RUN -> IDLE.
REQ-019 Exactly one X_en pulse per phase per accepted en; never two engine en asserted together.
REQ-020 S-memory mux combinational, same cycle: INIT_* selects init_*, KSA_* ksa_*, PRGA_* prga_*.
REQ-021 IDLE: s_addr=0, s_wrdata=0, s_wren=0; non-selected engine wren never reaches s_wren.
REQ-022 phase follows state: 0 IDLE, 1 INIT_*, 2 KSA_*, 3 PRGA_*.
REQ-023 Latency: en accepted at cycle N -> init_en at N+1 if init_rdy=1; rdy=1 one cycle after prga_rdy rises in PRGA_RUN.
REQ-024 en asserted in first IDLE cycle after PRGA completion is accepted (back-to-back runs).
REQ-025 key changes while rdy=0 do not affect key_q.

Reset
REQ-026 rst_n=0 -> immediately: state IDLE, rdy=1, key_q=0, phase=0, all X_en=0, s_wren=0.
REQ-027 Reset mid-run aborts; no engine en issued until next accepted en after release.
REQ-028 First en sampled on first rising edge with rst_n=1.

Configuration
REQ-029 Macro ARC4_SCHED_CYCLE_COUNT_EN defined -> output cycles (32) counts clock cycles from accepted en to rdy return, cleared on accept, held until next accept, 0 on reset, saturates at all ones.
REQ-030 Macro undefined -> no cycles port, no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package arc4_pkg holds state enum, phase encoding constants, S-memory width constants (ADDR_W=8, DATA_W=8), KEY_W=24.
REQ-032 One sub-module arc4_smem_mux (combinational 3:1 port mux selected by phase); FSM stays in arc4_sched.

Verification
REQ-033 Stub engines (init 256, ksa 768, prga 300 cycles busy); en with key=24'h1E4600 -> init_en, ksa_en, prga_en each pulse once in order, key_q=24'h1E4600, rdy=1 after prga finishes.
REQ-034 During KSA, init stub drives wren=1 addr=8'h55 -> s_wren/s_addr track ksa_* only; no stray write at 8'h55.
REQ-035 en pulsed again mid-KSA with key=24'h000001 -> ignored, key_q unchanged, no extra en pulses.
REQ-036 rst_n low 3 cycles during PRGA -> rdy=1, phase=0, s_wren=0 asynchronously; after release, no en pulses until new en.
REQ-037 ksa_rdy held 0 for 10 cycles at KSA_GO -> ksa_en stays 0, issued once in cycle ksa_rdy rises.
REQ-038 With ARC4_SCHED_CYCLE_COUNT_EN, stub run above -> cycles equals measured en-to-rdy count; second back-to-back run restarts from 0.
